// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard sequencer: load-use stall, redirect flush, memory freeze and halt.
// Latency: control outputs are combinational from state and inputs; Halted/StallCount are registered.
// Backpressure: MemBusy freezes every enable and holds state; HALT only exits through Reset.
module pipe_hazard_ctrl #(
    parameter int                 OPW          = 5,
    parameter int                 RW           = 5,
    parameter logic [OPW-1:0]     NOP_OP       = 5'b11111,
    parameter logic [OPW-1:0]     HALT_OP      = 5'b11110,
    parameter int                 LOAD_STALL   = 1,
    parameter int                 FLUSH_CYCLES = 1,
    parameter int                 CNTW         = 16
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [RW-1:0]   IdRs,
    input  logic [RW-1:0]   IdRt,
    input  logic [OPW-1:0]  IdOpcode,
    input  logic [RW-1:0]   ExRd,
    input  logic            ExMemRead,
    input  logic            BranchTaken,
    input  logic            Jump,
    input  logic            MemBusy,
    output logic            PcWrite,
    output logic            IfIdEnable,
    output logic            IfIdReset,
    output logic            IdExBubble,
    output logic            Halted,
    output logic [CNTW-1:0] StallCount
);

    typedef enum logic [1:0] {RUN, LSTALL, FLUSH, HALT} state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_enable;
        logic ifid_reset;
        logic idex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_enable: 1'b1, ifid_reset: 1'b0, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_enable: 1'b0, ifid_reset: 1'b0, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_enable: 1'b0, ifid_reset: 1'b1, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_enable: 1'b0, ifid_reset: 1'b0, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_enable: 1'b0, ifid_reset: 1'b1, idex_bubble: 1'b1};

    localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_STALL - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         LOAD_MULTI   = (LOAD_STALL > 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    ctrl_t      ctrl;
    logic       luse;
    logic       redirect;

    assign luse = ExMemRead && (ExRd != '0) && ((ExRd == IdRs) || (ExRd == IdRt))
                  && (IdOpcode != NOP_OP);
    assign redirect = BranchTaken || Jump;

    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == HALT) begin
            ctrl = CTRL_STALL;
        end else if (MemBusy) begin
            ctrl = CTRL_FREEZE;
        end else if (redirect) begin
            // A redirect from any live state restarts the flush window.
            ctrl = CTRL_FLUSH;
            if (FLUSH_MULTI) begin
                state_nxt = FLUSH;
                cnt_nxt   = FLUSH_RELOAD;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (luse) begin
                        ctrl = CTRL_STALL;
                        if (LOAD_MULTI) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = LOAD_RELOAD;
                        end
                    end else if (IdOpcode == HALT_OP) begin
                        ctrl      = CTRL_STALL;
                        state_nxt = HALT;
                    end
                end
                LSTALL: begin
                    ctrl = CTRL_STALL;
                    if (cnt <= 4'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    ctrl = CTRL_FLUSH;
                    if (cnt <= 4'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: begin
                    ctrl = CTRL_STALL;
                end
            endcase
        end
    end

    // Reset overrides the sequencer so the IF/ID register is held at NOP.
    assign PcWrite    = Reset ? CTRL_RESET.pc_write    : ctrl.pc_write;
    assign IfIdEnable = Reset ? CTRL_RESET.ifid_enable : ctrl.ifid_enable;
    assign IfIdReset  = Reset ? CTRL_RESET.ifid_reset  : ctrl.ifid_reset;
    assign IdExBubble = Reset ? CTRL_RESET.idex_bubble : ctrl.idex_bubble;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= RUN;
            cnt        <= '0;
            Halted     <= 1'b0;
            StallCount <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            Halted <= (state_nxt == HALT);
            if (!ctrl.pc_write && (StallCount != '1))
                StallCount <= StallCount + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with LOAD_STALL=2, FLUSH_CYCLES=3 and a narrow counter.
module tb_pipe_hazard_ctrl;

    localparam int         CNTW   = 8;
    localparam logic [4:0] NOP    = 5'b11111;
    localparam logic [4:0] HLT    = 5'b11110;
    // Expected {PcWrite, IfIdEnable, IfIdReset, IdExBubble}
    localparam logic [3:0] C_NORM = 4'b1100;
    localparam logic [3:0] C_STL  = 4'b0001;
    localparam logic [3:0] C_FLS  = 4'b1011;
    localparam logic [3:0] C_FRZ  = 4'b0000;
    // Stimulus flags {BranchTaken, Jump, MemBusy, ExMemRead}
    localparam logic [3:0] I_NONE = 4'b0000;
    localparam logic [3:0] I_LD   = 4'b0001;
    localparam logic [3:0] I_BR   = 4'b1000;
    localparam logic [3:0] I_JMP  = 4'b0100;
    localparam logic [3:0] I_MB   = 4'b0010;

    logic            clk = 1'b0;
    logic            Reset;
    logic [4:0]      IdRs, IdRt, IdOpcode, ExRd;
    logic            ExMemRead, BranchTaken, Jump, MemBusy;
    logic            PcWrite, IfIdEnable, IfIdReset, IdExBubble, Halted;
    logic [CNTW-1:0] StallCount;

    typedef struct packed {
        logic [3:0]      ctl;
        logic            halted;
        logic [CNTW-1:0] sc;
    } exp_t;

    exp_t            sb_q[$];
    int              checks   = 0;
    int              failures = 0;
    logic [CNTW-1:0] exp_sc   = '0;

    pipe_hazard_ctrl #(
        .OPW(5), .RW(5), .NOP_OP(NOP), .HALT_OP(HLT),
        .LOAD_STALL(2), .FLUSH_CYCLES(3), .CNTW(CNTW)
    ) dut (
        .clk(clk), .Reset(Reset),
        .IdRs(IdRs), .IdRt(IdRt), .IdOpcode(IdOpcode), .ExRd(ExRd),
        .ExMemRead(ExMemRead), .BranchTaken(BranchTaken), .Jump(Jump), .MemBusy(MemBusy),
        .PcWrite(PcWrite), .IfIdEnable(IfIdEnable), .IfIdReset(IfIdReset),
        .IdExBubble(IdExBubble), .Halted(Halted), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] fl, input logic [4:0] erd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] op);
        {BranchTaken, Jump, MemBusy, ExMemRead} = fl;
        ExRd = erd; IdRs = rs; IdRt = rt; IdOpcode = op;
    endtask

    // One pipeline cycle: drive after the edge, queue the expectation, compare mid-cycle.
    task automatic cyc(input string tag, input logic [3:0] fl, input logic [4:0] erd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] op,
                       input logic [3:0] ectl, input logic ehalt);
        exp_t e;
        @(posedge clk);
        #1;
        drive(fl, erd, rs, rt, op);
        sb_q.push_back('{ctl: ectl, halted: ehalt, sc: exp_sc});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_ctl"}, {28'd0, PcWrite, IfIdEnable, IfIdReset, IdExBubble}, {28'd0, e.ctl});
            check({tag, "_halted"}, {31'd0, Halted}, {31'd0, e.halted});
            check({tag, "_stallcnt"}, 32'(StallCount), 32'(e.sc));
        end
        if (!ectl[3] && exp_sc != '1)
            exp_sc = exp_sc + 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {28'd0, PcWrite, IfIdEnable, IfIdReset, IdExBubble}, 32'b0011);
        check({tag, "_halted"}, {31'd0, Halted}, 32'd0);
        check({tag, "_stallcnt"}, 32'(StallCount), 32'd0);
    endtask

    task automatic async_reset_pulse(input string tag);
        @(posedge clk);
        #2;
        drive(I_NONE, 5'd0, 5'd1, 5'd2, 5'd3);
        Reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        exp_sc = '0;
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        drive(I_NONE, 5'd0, 5'd1, 5'd2, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        Reset = 1'b0;

        cyc("run0", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_NORM, 1'b0);

        // Load-use on Rs: two stall cycles even after the hazard inputs drop.
        cyc("lu_rs0", I_LD, 5'd5, 5'd5, 5'd7, 5'd2, C_STL, 1'b0);
        cyc("lu_rs1", I_NONE, 5'd0, 5'd5, 5'd7, 5'd2, C_STL, 1'b0);
        cyc("lu_rs2", I_NONE, 5'd0, 5'd5, 5'd7, 5'd2, C_NORM, 1'b0);
        // No hazard when ExRd is r0 or ID holds a bubble.
        cyc("lu_r0", I_LD, 5'd0, 5'd0, 5'd0, 5'd2, C_NORM, 1'b0);
        cyc("lu_nop", I_LD, 5'd5, 5'd5, 5'd5, NOP, C_NORM, 1'b0);
        // Load-use on Rt.
        cyc("lu_rt0", I_LD, 5'd9, 5'd1, 5'd9, 5'd4, C_STL, 1'b0);
        cyc("lu_rt1", I_NONE, 5'd0, 5'd1, 5'd9, 5'd4, C_STL, 1'b0);
        cyc("lu_rt2", I_NONE, 5'd0, 5'd1, 5'd9, 5'd4, C_NORM, 1'b0);

        // Mid-cycle async reset clears the nonzero stall count immediately.
        async_reset_pulse("rst_async");
        cyc("post_rst", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_NORM, 1'b0);

        // Branch: three flush cycles total, no stall counting.
        cyc("br0", I_BR, 5'd0, 5'd1, 5'd2, 5'd3, C_FLS, 1'b0);
        cyc("br1", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_FLS, 1'b0);
        cyc("br2", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_FLS, 1'b0);
        cyc("br3", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_NORM, 1'b0);

        // Load-use together with a jump: the redirect wins.
        cyc("lujmp0", I_LD | I_JMP, 5'd6, 5'd6, 5'd1, 5'd2, C_FLS, 1'b0);
        cyc("lujmp1", I_LD, 5'd6, 5'd6, 5'd1, 5'd2, C_FLS, 1'b0);
        cyc("lujmp2", I_NONE, 5'd0, 5'd6, 5'd1, 5'd2, C_FLS, 1'b0);
        cyc("lujmp3", I_NONE, 5'd0, 5'd6, 5'd1, 5'd2, C_NORM, 1'b0);

        // Redirect arriving during a pending load stall overrides it.
        cyc("lsbr0", I_LD, 5'd3, 5'd3, 5'd1, 5'd2, C_STL, 1'b0);
        cyc("lsbr1", I_BR, 5'd0, 5'd3, 5'd1, 5'd2, C_FLS, 1'b0);
        cyc("lsbr2", I_NONE, 5'd0, 5'd3, 5'd1, 5'd2, C_FLS, 1'b0);
        cyc("lsbr3", I_NONE, 5'd0, 5'd3, 5'd1, 5'd2, C_FLS, 1'b0);
        cyc("lsbr4", I_NONE, 5'd0, 5'd3, 5'd1, 5'd2, C_NORM, 1'b0);

        // Freeze in RUN ignores a load-use hazard and a branch.
        cyc("frz_run", I_MB | I_LD | I_BR, 5'd4, 5'd4, 5'd1, 5'd2, C_FRZ, 1'b0);
        cyc("frz_rel", I_NONE, 5'd0, 5'd4, 5'd1, 5'd2, C_NORM, 1'b0);

        // Freeze for four cycles inside a flush with two cycles remaining.
        cyc("ffl0", I_BR, 5'd0, 5'd1, 5'd2, 5'd3, C_FLS, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("ffl_frz%0d", i), I_MB, 5'd0, 5'd1, 5'd2, 5'd3, C_FRZ, 1'b0);
        cyc("ffl1", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_FLS, 1'b0);
        cyc("ffl2", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_FLS, 1'b0);
        cyc("ffl3", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_NORM, 1'b0);

        // Halt: sticky, ignores redirect and freeze, counter saturates.
        cyc("hlt0", I_NONE, 5'd0, 5'd1, 5'd2, HLT, C_STL, 1'b0);
        cyc("hlt_br", I_BR, 5'd0, 5'd1, 5'd2, 5'd3, C_STL, 1'b1);
        cyc("hlt_mb", I_MB, 5'd0, 5'd1, 5'd2, 5'd3, C_STL, 1'b1);
        for (int i = 0; i < 300; i++)
            cyc("hlt_run", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_STL, 1'b1);
        check("sat_max", 32'(StallCount), 32'h0000_00FF);

        async_reset_pulse("rst_halt");
        cyc("after_halt", I_NONE, 5'd0, 5'd1, 5'd2, 5'd3, C_NORM, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
